// File: rtl/execute_memory_skid.sv
// EX/MEM pipeline register with valid/ready handshake, flush, bubble gating
// and an optional two-entry skid buffer that registers the upstream ready.
module execute_memory_skid #(
    parameter int DATA_WIDTH       = 32,
    parameter int REG_ADDR_WIDTH   = 5,
    parameter int RESULT_SRC_WIDTH = 2,
    parameter int SKID_EN          = 1,
    parameter int STALL_CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        FlushM,
    input  logic                        ValidE,
    output logic                        ReadyE,
    input  logic                        RegWriteE,
    input  logic                        MemWriteE,
    input  logic                        AddrModeE,
    input  logic [RESULT_SRC_WIDTH-1:0] ResultSrcE,
    input  logic [REG_ADDR_WIDTH-1:0]   RdE,
    input  logic [DATA_WIDTH-1:0]       ALUResultE,
    input  logic [DATA_WIDTH-1:0]       WriteDataE,
    input  logic [DATA_WIDTH-1:0]       PCPlus4E,
    input  logic [DATA_WIDTH-1:0]       ImmExtE,
    output logic                        ValidM,
    input  logic                        ReadyM,
    output logic                        RegWriteM,
    output logic                        MemWriteM,
    output logic                        AddrModeM,
    output logic [RESULT_SRC_WIDTH-1:0] ResultSrcM,
    output logic [REG_ADDR_WIDTH-1:0]   RdM,
    output logic [DATA_WIDTH-1:0]       ALUResultM,
    output logic [DATA_WIDTH-1:0]       WriteDataM,
    output logic [DATA_WIDTH-1:0]       PCPlus4M,
    output logic [DATA_WIDTH-1:0]       ImmExtM,
    output logic [STALL_CNT_WIDTH-1:0]  StallCountM
);

    typedef struct packed {
        logic                        reg_write;
        logic                        mem_write;
        logic                        addr_mode;
        logic [RESULT_SRC_WIDTH-1:0] result_src;
        logic [REG_ADDR_WIDTH-1:0]   rd;
        logic [DATA_WIDTH-1:0]       alu_result;
        logic [DATA_WIDTH-1:0]       write_data;
        logic [DATA_WIDTH-1:0]       pc_plus4;
        logic [DATA_WIDTH-1:0]       imm_ext;
    } bundle_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    function automatic logic [STALL_CNT_WIDTH-1:0] sat_inc(input logic [STALL_CNT_WIDTH-1:0] v);
        if (&v) return v;
        return v + {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t                     state_q, state_d;
    bundle_t                    main_q, main_d;
    bundle_t                    skid_q, skid_d;
    bundle_t                    in_b;
    logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;
    logic                       ready;
    logic                       accept;
    logic                       deliver;

    assign in_b = {RegWriteE, MemWriteE, AddrModeE, ResultSrcE, RdE,
                   ALUResultE, WriteDataE, PCPlus4E, ImmExtE};

    assign ValidM = (state_q != ST_EMPTY);

    // With the skid buffer, ready depends only on held state, so no ReadyM path reaches ReadyE.
    assign ready   = (SKID_EN != 0) ? (state_q != ST_FULL) : (~ValidM | ReadyM);
    assign ReadyE  = ready & ~rst;
    assign accept  = ValidE & ReadyE;
    assign deliver = ValidM & ReadyM;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        stall_d = stall_q;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = in_b;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && deliver) begin
                    main_d = in_b;
                end else if (accept && (SKID_EN != 0)) begin
                    skid_d  = in_b;
                    state_d = ST_FULL;
                end else if (deliver) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (deliver) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // A same-cycle accept may still load a data register; it is dropped because state empties.
        if (FlushM) state_d = ST_EMPTY;

        if (ValidM && !ReadyM) stall_d = sat_inc(stall_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

    assign RegWriteM   = main_q.reg_write & ValidM;
    assign MemWriteM   = main_q.mem_write & ValidM;
    assign AddrModeM   = main_q.addr_mode;
    assign ResultSrcM  = main_q.result_src;
    assign RdM         = main_q.rd;
    assign ALUResultM  = main_q.alu_result;
    assign WriteDataM  = main_q.write_data;
    assign PCPlus4M    = main_q.pc_plus4;
    assign ImmExtM     = main_q.imm_ext;
    assign StallCountM = stall_q;

endmodule

// File: doc/execute_memory_skid.md
Name: execute_memory_skid

Overview:
Parametrised successor to the plain EX/MEM register: carries the execute-stage bundle into the memory stage with valid/ready handshaking, synchronous flush, bubble gating and an optional two-entry skid buffer. This allows the memory stage to stall without a combinational ready path back into execute. A saturating stall counter supports performance debug. Sits between the execute-stage ALU/forwarding logic and the data-memory stage.

Parameters:
DATA_WIDTH, 32, width of ALUResult, WriteData, PCPlus4 and ImmExt
REG_ADDR_WIDTH, 5, destination register index width
RESULT_SRC_WIDTH, 2, ResultSrc field width
SKID_EN, 1, 1 = two-entry skid buffer with registered ReadyE; 0 = single register with combinational ReadyE
STALL_CNT_WIDTH, 16, width of the stall counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
FlushM  input  1  synchronous flush of all held entries
ValidE  input  1  execute bundle valid
ReadyE  output  1  block can accept the execute bundle
RegWriteE, MemWriteE, AddrModeE  input  1 each  control bits
ResultSrcE  input  RESULT_SRC_WIDTH  result mux select
RdE  input  REG_ADDR_WIDTH  destination register
ALUResultE, WriteDataE, PCPlus4E, ImmExtE  input  DATA_WIDTH each  datapath fields
ValidM  output  1  memory-side bundle valid
ReadyM  input  1  memory stage accepts the bundle
RegWriteM, MemWriteM, AddrModeM, ResultSrcM, RdM, ALUResultM, WriteDataM, PCPlus4M, ImmExtM  output  widths matching the E-side fields  registered bundle
StallCountM  output  STALL_CNT_WIDTH  cycles spent in the condition ValidM & ~ReadyM

Behaviour:
- Accept occurs when ValidE & ReadyE. Deliver occurs when ValidM & ReadyM. Bundle order is strictly FIFO.
- Reset (async assert, sync deassert use):
  - state EMPTY, ValidM=0, all data/control registers 0, StallCountM=0.
  - ReadyE is forced 0 while rst is high.
- Bubble gating: RegWriteM = stored RegWrite & ValidM; MemWriteM = stored MemWrite & ValidM. Other outputs show main-register contents regardless of ValidM.
- Latency: an accept into an EMPTY block gives ValidM=1 with that bundle on the next edge.
- SKID_EN=1, states EMPTY/ONE/FULL. ReadyE = (state != FULL) and is registered.
  - EMPTY + accept -> ONE; the bundle goes to the main register.
  - ONE + accept + deliver -> ONE; main is loaded with the new bundle.
  - ONE + accept, no deliver -> FULL; the new bundle goes to the skid register.
  - ONE + deliver, no accept -> EMPTY.
  - FULL + deliver -> ONE; skid moves to main. No accept is possible in FULL.
  - Any other combination holds state and registers.
- SKID_EN=0: ReadyE = ~ValidM | ReadyM (combinational). Only the main register exists; states are EMPTY and ONE only.
- FlushM:
  - Next state EMPTY, ValidM=0.
  - An accept in the same cycle is consumed (ReadyE stays as computed) and discarded.
  - A deliver in the same cycle still counts for the consumer.
  - Data registers need not be cleared.
  - Flush has priority over every other transition.
- StallCountM: increments each cycle ValidM & ~ReadyM, saturates at all-ones, and is cleared only by rst (not by FlushM).
- Data registers load only on their transfer events. No X propagates when ValidE=0.

Test Plan:
1. Reset then stream with ReadyM=1, ValidE=1, ALUResultE=0x10,0x20,0x30 on consecutive cycles -> ValidM high from cycle 1, ALUResultM=0x10,0x20,0x30 in order, ReadyE stays 1, StallCountM=0.
2. SKID_EN=1, drop ReadyM for 2 cycles while sending 0xA,0xB,0xC -> state FULL after 0xB, ReadyE=0 next cycle, 0xC held upstream; after ReadyM=1 the output order is 0xA,0xB,0xC with no loss or duplication, and StallCountM=2.
3. Bubble: ValidE=0 with RegWriteE=1, MemWriteE=1 -> ValidM=0, RegWriteM=0, MemWriteM=0.
4. FlushM asserted while FULL with ValidE=1 carrying 0xD -> next cycle ValidM=0, ReadyE=1; 0xD never appears; next accepted bundle 0xE appears after 1 cycle.
5. SKID_EN=0, ValidM=1, ReadyM=0 -> ReadyE=0 in the same cycle; raise ReadyM -> ReadyE=1 combinationally and accept+deliver complete in the same edge.
6. Assert rst mid-stream (state FULL, StallCountM=5) -> immediately ValidM=0, ReadyE=0, StallCountM=0, all outputs 0. Hold ReadyM=0 for 2^STALL_CNT_WIDTH+3 cycles -> StallCountM saturates at 0xFFFF.
